// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest digit count whose decimal range covers every WIDTH-bit value.
    function automatic int min_digits(input int width);
        longint max_value;
        longint power;
        int     digits;
        max_value = (longint'(1) <<< width) - 1;
        power     = 1;
        digits    = 0;
        while (power <= max_value) begin
            power  = power * 10;
            digits = digits + 1;
        end
        if (digits == 0) begin
            digits = 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a nibble of 5 or more gets 3 added before the shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [NIBBLE-1:0] value,
    output logic [NIBBLE-1:0] result
);

    assign result = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with a start/busy/done handshake.
// Define BIN2BCD_LZ_BLANK_EN to add the registered leading-zero blanking output.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         bin,
    output logic                     busy,
    output logic                     done,
    output logic [NIBBLE*DIGITS-1:0] bcd
`ifdef BIN2BCD_LZ_BLANK_EN
    ,
    output logic [DIGITS-1:0]        blank
`endif
);

    localparam int BCD_W = NIBBLE * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
            $error("bin2bcd_seq: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [SR_W-1:0]    sr;
    logic [BCD_W-1:0]   adj;
    logic [SR_W-1:0]    adj_full;
    logic [CNT_W-1:0]   count;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .value  (sr[WIDTH + NIBBLE*i +: NIBBLE]),
            .result (adj[NIBBLE*i +: NIBBLE])
        );
    end

    // Corrected digits over the untouched binary tail; shifting this is one full step.
    assign adj_full = {adj, sr[WIDTH-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (sr[WIDTH + NIBBLE*i +: NIBBLE] == '0);
            blank_next[i] = zero_above;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            count <= '0;
            done  <= 1'b0;
            bcd   <= '0;
`ifdef BIN2BCD_LZ_BLANK_EN
            blank <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {{BCD_W{1'b0}}, bin};
                        count <= '0;
                    end
                end
                SHIFT: begin
                    sr    <= adj_full << 1;
                    count <= count + CNT_W'(1);
                end
                DONE: begin
                    bcd  <= sr[SR_W-1 -: BCD_W];
                    done <= 1'b1;
`ifdef BIN2BCD_LZ_BLANK_EN
                    blank <= blank_next;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq; expected digits come from decimal arithmetic.
module tb_bin2bcd_seq;

    localparam int WIDTH   = 12;
    localparam int DIGITS  = 4;
    localparam int LATENCY = WIDTH + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_LZ_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    int tests = 0;
    int fails = 0;
    logic [4*DIGITS-1:0] last_bcd;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_LZ_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int value);
        logic [4*DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_blank(input int value);
        logic [DIGITS-1:0] r;
        int limit;
        r = '0;
        limit = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (value < limit);
            limit = limit * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Full handshake for one value: latency, busy, held output, result, single-cycle done.
    task automatic convert(input int value);
        int  lat;
        bit  busy_ok;
        bit  hold_ok;
        @(negedge clk);
        start = 1'b1;
        bin   = WIDTH'(value);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = ~bin;
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!done) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (bcd !== last_bcd) hold_ok = 1'b0;
            end
        end while (!done && lat < 40);
        check($sformatf("latency(%0d)", value), 32'(lat), 32'(LATENCY));
        check($sformatf("busy_during(%0d)", value), 32'(busy_ok), 32'd1);
        check($sformatf("bcd_hold(%0d)", value), 32'(hold_ok), 32'd1);
        check($sformatf("bcd(%0d)", value), 32'(bcd), 32'(ref_bcd(value)));
`ifdef BIN2BCD_LZ_BLANK_EN
        check($sformatf("blank(%0d)", value), 32'(blank), 32'(ref_blank(value)));
`endif
        last_bcd = ref_bcd(value);
        @(negedge clk);
        check($sformatf("done_pulse(%0d)", value), 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int done_count;
        int first_done;
        int second_done;
        int stray;

        rst      = 1'b1;
        start    = 1'b0;
        bin      = '0;
        last_bcd = '0;

        // Reset, then a long idle stretch.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_outputs", {busy, done, bcd}, 32'd0);
        end
`ifdef BIN2BCD_LZ_BLANK_EN
        check("blank_reset", 32'(blank), 32'd0);
`endif

        // Boundary values and ordered pair.
        convert(0);
        convert(4095);
        convert(1234);
        convert(7);
        convert(305);
        convert(0);
        convert(4095);

        // start held high for 30 edges: accepts at edge 0 and 14 only.
        @(negedge clk);
        start = 1'b1;
        bin   = WIDTH'(999);
        done_count  = 0;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_count++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held_start_count", 32'(done_count), 32'd2);
        check("held_start_first", 32'(first_done), 32'd13);
        check("held_start_second", 32'(second_done), 32'd27);
        check("held_start_bcd", 32'(bcd), 32'h0999);
        repeat (20) @(negedge clk);
        last_bcd = ref_bcd(999);
        check("held_start_settle", {busy, bcd}, 32'h0999);

        // Reset after six shifts aborts the conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = WIDTH'(2048);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {busy, done, bcd}, 32'd0);
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        check("abort_no_done", 32'(stray), 32'd0);
        last_bcd = '0;
        convert(7);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = WIDTH'(55);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_beats_start", {busy, done, bcd}, 32'd0);
        last_bcd = '0;

        // Randomized values against the decimal model.
        for (int n = 0; n < 24; n++) begin
            convert(int'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

endmodule
